test_sequencer: RTL and testbench
=================================

TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter NUM_RST, default 2: number of staggered reset outputs, 1..8.
REQ-002 Parameter NUM_CH, default 2: number of success/failure status channels, 1..16.
REQ-003 Parameter CNT_W, default 32: cycle counter and delay width, 8..64.
REQ-004 clock  input  1  single clock for all logic.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a test run.
REQ-007 rst_delay  input  NUM_RST*CNT_W  per-output release cycle; slice i is bits [i*CNT_W +: CNT_W].
REQ-008 max_cycles  input  CNT_W  timeout limit; 0 means no limit.
REQ-009 success  input  NUM_CH  per-channel success level.
REQ-010 failure  input  NUM_CH  per-channel failure level.
REQ-011 rst_out  output  NUM_RST  active-high domain resets.
REQ-012 cycle_count  output  CNT_W  cycles elapsed since start.
REQ-013 busy, done, pass, fail  output  1 each  run status.
REQ-014 reason  output  2  00 pass/none, 01 channel failure, 10 timeout, 11 unused.
REQ-015 fail_mask  output  NUM_CH  failure bits captured at the terminating cycle.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, RST_SEQ, RUN, DONE.
REQ-017 In IDLE, all rst_out bits SHALL be 1 and cycle_count SHALL hold its value; start moves the FSM to RST_SEQ and clears cycle_count to 0.
REQ-018 In RST_SEQ and RUN, cycle_count SHALL increment by 1 per cycle and saturate at all-ones.
REQ-019 rst_out[i] SHALL be registered and go 0 on the first clock edge where cycle_count >= rst_delay slice i; once 0 it stays 0 until the FSM leaves RUN.
REQ-020 The FSM SHALL move from RST_SEQ to RUN on the cycle after all rst_out bits are 0; any rst_delay of 0 releases that output one cycle after start.
REQ-021 success and failure SHALL be sampled only in RUN.
REQ-022 A sticky success mask SHALL record each channel whose success bit has been 1 in RUN; pass triggers when the mask is all ones.
REQ-023 Any failure bit = 1 in RUN SHALL terminate with reason 01 and fail_mask = failure.
REQ-024 Timeout SHALL terminate with reason 10 when max_cycles != 0 and cycle_count > max_cycles, evaluated in RST_SEQ and RUN.
REQ-025 Same-cycle priority SHALL be channel failure > timeout > pass.
REQ-026 On termination, the FSM SHALL enter DONE on the next edge, assert done, assert exactly one of pass/fail, and reassert all rst_out bits.
REQ-027 done, pass, fail, reason, fail_mask and cycle_count SHALL hold in DONE until the next start, which behaves as in REQ-017 and clears status.
REQ-028 busy SHALL be 1 exactly in RST_SEQ and RUN; start while busy SHALL be ignored.
REQ-029 Inputs rst_delay and max_cycles SHALL be sampled every cycle, not latched at start.

Reset
REQ-030 On reset_n = 0, the FSM SHALL enter IDLE asynchronously: rst_out all 1; cycle_count 0; busy, done, pass and fail 0; reason 00; fail_mask 0; sticky mask 0.
REQ-031 Reset mid-run SHALL abandon the run with no done pulse; the first edge after release sees IDLE.

Configuration
REQ-032 Macro TEST_SEQUENCER_TIMEOUT_EN defined: the timeout logic of REQ-024 is compiled in.
REQ-033 Macro TEST_SEQUENCER_TIMEOUT_EN undefined: max_cycles is ignored, reason 10 is never produced, and the port list is unchanged.

Verification
REQ-034 Defaults, rst_delay = {7,3}, start at cycle 0: rst_out[0] falls when count = 3, rst_out[1] falls when count = 7, RUN begins the next cycle.
REQ-035 RUN; success[0] pulses once, success[1] is high 5 cycles later: pass = 1, reason = 00, done = 1 one cycle later, rst_out = 11.
REQ-036 RUN; failure = 10 in the same cycle the success mask completes: fail = 1, reason = 01, fail_mask = 10.
REQ-037 max_cycles = 20, no success: fail with reason 10 and cycle_count = 21 held; with the macro undefined, busy remains 1 at cycle 100.
REQ-038 reset_n low mid-RUN, then start during busy, then start in DONE: async return to IDLE with all outputs zeroed; the busy start is ignored; the DONE start clears status and restarts from count 0.
REQ-039 CNT_W = 8 with max_cycles = 0: cycle_count saturates at 255 with no wrap.

Source files
------------

// File: rtl/test_sequencer.sv
// test_sequencer: staggered reset release followed by a monitored test run.
// After start, each rst_out bit is released once the cycle counter reaches
// its delay. When all are released the run phase watches the per-channel
// success/failure inputs until every channel has succeeded, any channel
// fails, or (optionally) a cycle limit is exceeded.
// Build option: define TEST_SEQUENCER_TIMEOUT_EN to compile in the timeout
// check against max_cycles; without it max_cycles is ignored.
module test_sequencer #(
    parameter int NUM_RST = 2,
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [NUM_RST*CNT_W-1:0] rst_delay,
    input  logic [CNT_W-1:0]         max_cycles,
    input  logic [NUM_CH-1:0]        success,
    input  logic [NUM_CH-1:0]        failure,
    output logic [NUM_RST-1:0]       rst_out,
    output logic [CNT_W-1:0]         cycle_count,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic [1:0]               reason,
    output logic [NUM_CH-1:0]        fail_mask
);

    typedef enum logic [1:0] {
        IDLE,
        RST_SEQ,
        RUN,
        DONE
    } state_t;

    localparam logic [1:0] REASON_NONE    = 2'b00;
    localparam logic [1:0] REASON_CHANNEL = 2'b01;
    localparam logic [1:0] REASON_TIMEOUT = 2'b10;

    state_t             state;
    logic [NUM_CH-1:0]  seen;         // channels that have reported success in RUN
    logic [CNT_W-1:0]   count_next;
    logic [NUM_RST-1:0] release_now;
    logic               timeout;
    logic               all_pass;

    // Saturating counter increment, per-output release compare, run verdicts.
    always_comb begin
        // NOTE: every combinational output is assigned a default first so no latch is inferred.
        count_next  = cycle_count;
        release_now = '0;
        if (cycle_count != '1) begin
            count_next = cycle_count + 1'b1;
        end
        for (int i = 0; i < NUM_RST; i++) begin
            release_now[i] = (cycle_count >= rst_delay[i*CNT_W +: CNT_W]);
        end
        all_pass = &(seen | success);
    end

`ifdef TEST_SEQUENCER_TIMEOUT_EN
    assign timeout = (max_cycles != '0) && (cycle_count > max_cycles);
`else
    // max_cycles stays on the port list but has no effect in this build.
    logic unused_max_cycles;
    assign unused_max_cycles = ^max_cycles;
    assign timeout           = 1'b0;
`endif

    // Sequencer FSM with all status outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state       <= IDLE;
            rst_out     <= '1;
            cycle_count <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            reason      <= REASON_NONE;
            fail_mask   <= '0;
            seen        <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    rst_out <= '1;
                    if (start) begin
                        state       <= RST_SEQ;
                        cycle_count <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                        reason      <= REASON_NONE;
                        fail_mask   <= '0;
                        seen        <= '0;
                    end
                end
                RST_SEQ: begin
                    if (timeout) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        fail    <= 1'b1;
                        reason  <= REASON_TIMEOUT;
                        rst_out <= '1;
                    end else begin
                        cycle_count <= count_next;
                        rst_out     <= rst_out & ~release_now;
                        // Enter RUN one cycle after the last output is released.
                        if (rst_out == '0) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    seen <= seen | success;
                    if (|failure) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        fail      <= 1'b1;
                        reason    <= REASON_CHANNEL;
                        fail_mask <= failure;
                        rst_out   <= '1;
                    end else if (timeout) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        fail    <= 1'b1;
                        reason  <= REASON_TIMEOUT;
                        rst_out <= '1;
                    end else if (all_pass) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        pass    <= 1'b1;
                        reason  <= REASON_NONE;
                        rst_out <= '1;
                    end else begin
                        cycle_count <= count_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_test_sequencer.sv
// Directed testbench for test_sequencer: reset state, staggered release,
// pass, channel failure with priority, timeout (or its absence), mid-run
// reset, start while busy, restart from DONE, and 8-bit counter saturation.
module tb_test_sequencer;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [63:0] rst_delay;
    logic [31:0] max_cycles;
    logic [1:0]  success;
    logic [1:0]  failure;
    logic [1:0]  rst_out;
    logic [31:0] cycle_count;
    logic        busy, done, pass, fail;
    logic [1:0]  reason;
    logic [1:0]  fail_mask;

    // Narrow-counter instance for the saturation check.
    logic        start8;
    logic [7:0]  rst_delay8;
    logic [7:0]  max_cycles8;
    logic [0:0]  success8, failure8, rst_out8, fail_mask8;
    logic [7:0]  cycle_count8;
    logic        busy8, done8, pass8, fail8;
    logic [1:0]  reason8;

    int n_tests = 0;
    int n_fail  = 0;

    test_sequencer dut (
        .clock(clock), .reset_n(reset_n), .start(start), .rst_delay(rst_delay),
        .max_cycles(max_cycles), .success(success), .failure(failure),
        .rst_out(rst_out), .cycle_count(cycle_count), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .reason(reason), .fail_mask(fail_mask)
    );

    test_sequencer #(.NUM_RST(1), .NUM_CH(1), .CNT_W(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .rst_delay(rst_delay8),
        .max_cycles(max_cycles8), .success(success8), .failure(failure8),
        .rst_out(rst_out8), .cycle_count(cycle_count8), .busy(busy8), .done(done8),
        .pass(pass8), .fail(fail8), .reason(reason8), .fail_mask(fail_mask8)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        rst_delay   = {32'd7, 32'd3};
        max_cycles  = 32'd0;
        success     = 2'b00;
        failure     = 2'b00;
        start8      = 1'b0;
        rst_delay8  = 8'd0;
        max_cycles8 = 8'd0;
        success8    = 1'b0;
        failure8    = 1'b0;
        tick(2);

        // Reset state
        check("rst_rst_out", rst_out, 2'b11);
        check("rst_count", cycle_count, 0);
        check("rst_flags", {busy, done, pass, fail}, 4'b0000);
        check("rst_reason", reason, 2'b00);
        check("rst_fail_mask", fail_mask, 2'b00);
        reset_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Staggered release with delays {7,3}
        pulse_start();
        check("seq_start_count", cycle_count, 0);
        check("seq_start_busy", busy, 1);
        tick(3);
        check("seq_c3_rst_out", rst_out, 2'b11);
        tick();
        check("seq_c4_rst_out", rst_out, 2'b10);
        check("seq_c4_count", cycle_count, 4);
        tick(4);
        check("seq_c8_rst_out", rst_out, 2'b00);
        tick();
        check("seq_c9_count", cycle_count, 9);

        // Pass: success[0] pulse, success[1] five cycles later
        success = 2'b01;
        tick();
        success = 2'b00;
        tick(4);
        check("pass_pending_done", done, 0);
        success = 2'b10;
        tick();
        success = 2'b00;
        check("pass_flags", {busy, done, pass, fail}, 4'b0110);
        check("pass_reason", reason, 2'b00);
        check("pass_rst_out", rst_out, 2'b11);
        check("pass_count", cycle_count, 14);
        tick(3);
        check("pass_hold_count", cycle_count, 14);
        check("pass_hold_done", {done, pass}, 2'b11);

        // Channel failure in the cycle the success mask completes
        rst_delay = {32'd1, 32'd0};
        success   = 2'b11;
        pulse_start();
        check("cf_cleared", {done, pass, fail}, 3'b000);
        tick(3);
        check("cf_release", rst_out, 2'b00);
        success = 2'b00;
        tick();
        check("cf_rstseq_success_ignored", done, 0);
        success = 2'b01;
        tick();
        success = 2'b10;
        failure = 2'b10;
        tick();
        success = 2'b00;
        failure = 2'b00;
        check("cf_flags", {busy, done, pass, fail}, 4'b0101);
        check("cf_reason", reason, 2'b01);
        check("cf_fail_mask", fail_mask, 2'b10);
        check("cf_count", cycle_count, 5);

        // Timeout with max_cycles = 20
        rst_delay  = {32'd0, 32'd0};
        max_cycles = 32'd20;
        pulse_start();
`ifdef TEST_SEQUENCER_TIMEOUT_EN
        tick(21);
        check("to_c21_busy", busy, 1);
        tick();
        check("to_flags", {busy, done, pass, fail}, 4'b0101);
        check("to_reason", reason, 2'b10);
        check("to_count", cycle_count, 21);
        tick(2);
        check("to_hold_count", cycle_count, 21);
`else
        tick(100);
        check("to_disabled_busy", busy, 1);
        check("to_disabled_count", cycle_count, 100);
        check("to_disabled_done", done, 0);
`endif
        max_cycles = 32'd0;

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_rst_out", rst_out, 2'b11);
        check("ar_count", cycle_count, 0);
        check("ar_flags", {busy, done, pass, fail}, 4'b0000);
        check("ar_reason", reason, 2'b00);
        reset_n = 1'b1;
        tick();
        check("ar_idle_after", {busy, done}, 2'b00);
        check("ar_idle_count", cycle_count, 0);

        // Start while busy is ignored; start in DONE restarts
        pulse_start();
        tick(3);
        check("bs_count3", cycle_count, 3);
        pulse_start();
        check("bs_ignored_count", cycle_count, 4);
        check("bs_busy", busy, 1);
        success = 2'b11;
        tick();
        success = 2'b00;
        check("bs_pass", {done, pass}, 2'b11);
        check("bs_count", cycle_count, 4);
        pulse_start();
        check("rs_cleared", {busy, done, pass, fail}, 4'b1000);
        check("rs_count", cycle_count, 0);
        check("rs_rst_out", rst_out, 2'b11);
        tick();
        check("rs_count1", cycle_count, 1);

        // 8-bit counter saturates at 255
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick(200);
        check("sat_count200", cycle_count8, 200);
        tick(100);
        check("sat_count255", cycle_count8, 255);
        check("sat_busy", busy8, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
